detect_sequence_param_fsm: RTL and testbench

//  Runtime-programmable serial sequence detector; successor to the fixed 4/6-bit detectors.

---
 rtl/detect_sequence_param_fsm.sv | 168 ++++++++++++++++
 tb/tb_detect_sequence_param_fsm.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/detect_sequence_param_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : detect_sequence_param_fsm
//  Description : Runtime-programmable serial sequence detector. Matches a
//                1..MAX_LEN bit pattern on a valid-qualified bit stream with
//                KMP-style fallback, optional overlap, and a saturating
//                match counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module detect_sequence_param_fsm #(
    parameter int                   MAX_LEN     = 8,
    parameter int                   CNT_W       = 8,
    parameter logic [MAX_LEN-1:0]   DEF_PATTERN = MAX_LEN'(6'b110011),
    parameter int                   DEF_LEN     = 6
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_we,
    input  logic [MAX_LEN-1:0]             cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
    input  logic                           cfg_overlap,
    input  logic                           a_valid,
    input  logic                           a,
    input  logic                           cnt_clr,
    output logic                           detected,
    output logic [CNT_W-1:0]               match_count,
    output logic [$clog2(MAX_LEN+1)-1:0]   progress
);

    localparam int                LEN_W     = $clog2(MAX_LEN + 1);
    localparam int                IDX_W     = $clog2(MAX_LEN);
    localparam logic [LEN_W-1:0]  C_MAX_LEN = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]  C_HIST_MX = LEN_W'(MAX_LEN - 1);
    localparam logic [LEN_W-1:0]  C_DEF_LEN = LEN_W'(DEF_LEN);

    // Coarse state class; the exact position within the pattern is k_q.
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PARTIAL = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [MAX_LEN-1:0]     pattern_q, pattern_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic                   overlap_q, overlap_d;
    logic [LEN_W-1:0]       k_q, k_d;
    // Previous accepted bits since the last restart; bit 0 is the newest.
    // One bit short of MAX_LEN because the incoming bit completes the window.
    logic [MAX_LEN-2:0]     hist_q, hist_d;
    logic [LEN_W-1:0]       hcnt_q, hcnt_d;
    logic                   detected_q, detected_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic [MAX_LEN-1:0]     hist_nxt;
    logic [LEN_W-1:0]       hcnt_nxt;
    logic [LEN_W-1:0]       m_full;
    logic [LEN_W-1:0]       m_border;
    logic                   seg_ok;
    logic [IDX_W-1:0]       pidx;
    logic                   match;

    assign hist_nxt = {hist_q, a};
    assign hcnt_nxt = hcnt_q + 1'b1;

    // Longest pattern prefix that ends the bit window including the new bit
    // (m_full), and the longest one strictly shorter than len (m_border).
    always_comb begin
        m_full   = '0;
        m_border = '0;
        seg_ok   = 1'b0;
        pidx     = '0;
        for (int j = 1; j <= MAX_LEN; j++) begin
            if (j <= int'(len_q) && j <= int'(hcnt_nxt)) begin
                seg_ok = 1'b1;
                for (int i = 0; i < MAX_LEN; i++) begin
                    if (i < j) begin
                        pidx = IDX_W'(int'(len_q) - j + i);
                        if (hist_nxt[IDX_W'(i)] != pattern_q[pidx]) begin
                            seg_ok = 1'b0;
                        end
                    end
                end
                if (seg_ok) begin
                    m_full = LEN_W'(j);
                    if (j < int'(len_q)) begin
                        m_border = LEN_W'(j);
                    end
                end
            end
        end
    end

    // Next-state, configuration load, match pulse and counter update.
    always_comb begin
        pattern_d  = pattern_q;
        len_d      = len_q;
        overlap_d  = overlap_q;
        k_d        = k_q;
        hist_d     = hist_q;
        hcnt_d     = hcnt_q;
        count_d    = count_q;
        match      = 1'b0;
        if (cfg_we) begin
            // Reconfiguration restarts the search; the data bit is dropped.
            pattern_d = cfg_pattern;
            len_d     = (cfg_len > C_MAX_LEN) ? C_MAX_LEN : cfg_len;
            overlap_d = cfg_overlap;
            k_d       = '0;
            hist_d    = '0;
            hcnt_d    = '0;
        end else if (a_valid) begin
            hist_d = hist_nxt[MAX_LEN-2:0];
            hcnt_d = (hcnt_nxt > C_HIST_MX) ? C_HIST_MX : hcnt_nxt;
            if ((len_q != '0) && (m_full == len_q)) begin
                match = 1'b1;
                if (overlap_q) begin
                    k_d = m_border;
                end else begin
                    k_d    = '0;
                    hist_d = '0;
                    hcnt_d = '0;
                end
            end else begin
                k_d = m_full;
            end
        end
        state_d    = (k_d == '0) ? ST_IDLE : ST_PARTIAL;
        detected_d = match;
        // A clear takes priority over a simultaneous match.
        if (cnt_clr) begin
            count_d = '0;
        end else if (match && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // State and configuration registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pattern_q  <= DEF_PATTERN;
            len_q      <= C_DEF_LEN;
            overlap_q  <= 1'b1;
            k_q        <= '0;
            hist_q     <= '0;
            hcnt_q     <= '0;
            detected_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pattern_q  <= pattern_d;
            len_q      <= len_d;
            overlap_q  <= overlap_d;
            k_q        <= k_d;
            hist_q     <= hist_d;
            hcnt_q     <= hcnt_d;
            detected_q <= detected_d;
            count_q    <= count_d;
        end
    end

    assign detected    = detected_q;
    assign match_count = count_q;
    assign progress    = (state_q == ST_IDLE) ? '0 : k_q;

endmodule
`default_nettype wire

// File: tb/tb_detect_sequence_param_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_detect_sequence_param_fsm
//  Description : Scoreboard bench for detect_sequence_param_fsm. Stimulus
//                pushes expected pulses (edge index + count); a negedge
//                monitor pops and compares whenever detected is high.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_detect_sequence_param_fsm;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cfg_we = 1'b0;
    logic [MAX_LEN-1:0]   cfg_pattern = '0;
    logic [LW-1:0]        cfg_len = '0;
    logic                 cfg_overlap = 1'b0;
    logic                 a_valid = 1'b0;
    logic                 a = 1'b0;
    logic                 cnt_clr = 1'b0;
    logic                 detected;
    logic [CNT_W-1:0]     match_count;
    logic [LW-1:0]        progress;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    detect_sequence_param_fsm #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .a_valid     (a_valid),
        .a           (a),
        .cnt_clr     (cnt_clr),
        .detected    (detected),
        .match_count (match_count),
        .progress    (progress)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one edge; if a pulse is expected from this edge, queue it.
    task automatic tick(input bit exp_det, input int exp_cnt);
        @(posedge clk);
        #1;
        if (exp_det) begin
            exp_t e;
            e.cyc = cyc;
            e.cnt = exp_cnt;
            sb.push_back(e);
        end
    endtask

    task automatic send(input bit v, input bit b, input bit exp_det, input int exp_cnt);
        a_valid = v;
        a       = b;
        cfg_we  = 1'b0;
        cnt_clr = 1'b0;
        tick(exp_det, exp_cnt);
        a_valid = 1'b0;
    endtask

    task automatic do_cfg(input logic [MAX_LEN-1:0] pat, input logic [LW-1:0] len, input bit ov);
        cfg_we      = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        a_valid     = 1'b0;
        tick(1'b0, 0);
        cfg_we      = 1'b0;
    endtask

    task automatic clear_cnt();
        cnt_clr = 1'b1;
        a_valid = 1'b0;
        tick(1'b0, 0);
        cnt_clr = 1'b0;
        check("cnt_clr", int'(match_count), 0);
    endtask

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (detected === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: got pulse at edge %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_edge", cyc, e.cyc);
                check("pulse_count", int'(match_count), e.cnt);
            end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL missed_pulse: got no pulse at edge %0d, expected one", sb[0].cyc);
            void'(sb.pop_front());
        end
    end

    initial begin
        logic [9:0] s10;
        s10 = 10'b1100110011;

        // Reset state
        rst = 1'b1;
        tick(1'b0, 0);
        tick(1'b0, 0);
        check("rst_detected", int'(detected), 0);
        check("rst_count", int'(match_count), 0);
        check("rst_progress", int'(progress), 0);
        rst = 1'b0;

        // 1: default pattern, overlapping
        for (int i = 0; i < 10; i++) begin
            send(1'b1, s10[9-i], (i == 5) || (i == 9), (i == 5) ? 1 : 2);
            if (i == 5) check("t1_border_k", int'(progress), 2);
        end
        check("t1_count", int'(match_count), 2);

        // 2: non-overlapping
        clear_cnt();
        do_cfg(8'b0011_0011, 4'd6, 1'b0);
        for (int i = 0; i < 10; i++) begin
            send(1'b1, s10[9-i], (i == 5), 1);
        end
        check("t2_count", int'(match_count), 1);
        check("t2_progress", int'(progress), 2);

        // 3: pattern 1010 with gaps and KMP fallback
        clear_cnt();
        do_cfg(8'b0000_1010, 4'd4, 1'b1);
        send(1'b1, 1'b1, 1'b0, 0);
        send(1'b0, 1'b0, 1'b0, 0);
        send(1'b1, 1'b0, 1'b0, 0);
        send(1'b0, 1'b1, 1'b0, 0);
        send(1'b1, 1'b1, 1'b0, 0);
        check("t3_k3", int'(progress), 3);
        send(1'b1, 1'b1, 1'b0, 0);
        check("t3_fallback_k1", int'(progress), 1);
        send(1'b0, 1'b0, 1'b0, 0);
        send(1'b1, 1'b0, 1'b0, 0);
        send(1'b1, 1'b1, 1'b0, 0);
        send(1'b0, 1'b1, 1'b0, 0);
        send(1'b1, 1'b0, 1'b1, 1);
        check("t3_border_k", int'(progress), 2);

        // 4: cfg_we mid-pattern restarts and drops its data bit
        clear_cnt();
        do_cfg(8'b0011_0011, 4'd6, 1'b1);
        send(1'b1, 1'b1, 1'b0, 0);
        send(1'b1, 1'b1, 1'b0, 0);
        send(1'b1, 1'b0, 1'b0, 0);
        send(1'b1, 1'b0, 1'b0, 0);
        send(1'b1, 1'b1, 1'b0, 0);
        check("t4_k5", int'(progress), 5);
        cfg_we = 1'b1; cfg_pattern = 8'b0000_0110; cfg_len = 4'd4; cfg_overlap = 1'b1;
        a_valid = 1'b1; a = 1'b1;
        tick(1'b0, 0);
        cfg_we = 1'b0; a_valid = 1'b0;
        check("t4_cfg_k0", int'(progress), 0);
        send(1'b1, 1'b1, 1'b0, 0);
        check("t4_after1_k0", int'(progress), 0);
        send(1'b1, 1'b0, 1'b0, 0);
        send(1'b1, 1'b1, 1'b0, 0);
        send(1'b1, 1'b1, 1'b0, 0);
        send(1'b1, 1'b0, 1'b1, 1);
        check("t4_count", int'(match_count), 1);

        // cfg_len above MAX_LEN is clamped to MAX_LEN
        clear_cnt();
        do_cfg(8'b1000_0001, 4'd15, 1'b1);
        send(1'b1, 1'b1, 1'b0, 0);
        for (int i = 0; i < 6; i++) send(1'b1, 1'b0, 1'b0, 0);
        check("tc_k7", int'(progress), 7);
        send(1'b1, 1'b1, 1'b1, 1);

        // 5: len 1, back-to-back pulses, saturation, clear vs match
        clear_cnt();
        do_cfg(8'b0000_0001, 4'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 1'b1, 1'b1, (i < 3) ? i + 1 : 3);
        end
        check("t5_saturated", int'(match_count), 3);
        a_valid = 1'b1; a = 1'b1; cnt_clr = 1'b1;
        tick(1'b1, 0);
        cnt_clr = 1'b0; a_valid = 1'b0;
        send(1'b1, 1'b1, 1'b1, 1);
        send(1'b0, 1'b0, 1'b0, 0);

        // 6: len 0 disables detection
        do_cfg(8'b1111_1111, 4'd0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            send(1'b1, 1'($urandom_range(1, 0)), 1'b0, 0);
        end
        check("t6_progress", int'(progress), 0);
        check("t6_count", int'(match_count), 1);

        // rst on the completing bit: no pulse, everything cleared
        do_cfg(8'b0011_0011, 4'd6, 1'b0);
        send(1'b1, 1'b1, 1'b0, 0);
        send(1'b1, 1'b1, 1'b0, 0);
        send(1'b1, 1'b0, 1'b0, 0);
        send(1'b1, 1'b0, 1'b0, 0);
        send(1'b1, 1'b1, 1'b0, 0);
        rst = 1'b1; a_valid = 1'b1; a = 1'b1;
        tick(1'b0, 0);
        rst = 1'b0; a_valid = 1'b0;
        check("rst_mid_detected", int'(detected), 0);
        check("rst_mid_count", int'(match_count), 0);
        check("rst_mid_progress", int'(progress), 0);

        // Defaults (including overlap) restored after reset
        for (int i = 0; i < 10; i++) begin
            send(1'b1, s10[9-i], (i == 5) || (i == 9), (i == 5) ? 1 : 2);
        end

        repeat (3) send(1'b0, 1'b0, 1'b0, 0);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
